tlb_op_sequencer: RTL and testbench

TLB_OP_SEQUENCER -- requirements
Module: tlb_op_sequencer

---
 rtl/core_config.sv | 6 +
 rtl/tlb_types.sv | 12 +
 rtl/tlb_op_sequencer.sv | 141 ++++++++++++++
 tb/tb_tlb_op_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_config.sv
// Core-wide configuration constants shared by the commit-stage blocks.
package core_config;

    localparam int unsigned CommitWidth = 2;

endpackage

// File: rtl/tlb_types.sv
// Shared TLB maintenance op encodings.
package tlb_types;

    typedef enum logic [2:0] {
        TlbSrch = 3'd0,
        TlbRd   = 3'd1,
        TlbWr   = 3'd2,
        TlbFill = 3'd3,
        TlbInv  = 3'd4
    } tlb_op_t;

endpackage

// File: rtl/tlb_op_sequencer.sv
// Serialises committed TLB maintenance ops onto the single TLB port, stalling the pipeline
// until they finish and then requesting a refetch at the next PC.
module tlb_op_sequencer
    import tlb_types::*;
#(
    parameter int unsigned COMMIT_WIDTH = core_config::CommitWidth,
    parameter int unsigned TLB_IDX_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [COMMIT_WIDTH-1:0]   op_valid_i,
    input  logic [3*COMMIT_WIDTH-1:0] op_type_i,
    input  logic [5*COMMIT_WIDTH-1:0] inv_op_i,
    input  logic                      flush_i,
    output logic                      tlb_req_o,
    output logic [2:0]                tlb_op_o,
    output logic [4:0]                tlb_inv_op_o,
    input  logic                      tlb_ack_i,
    input  logic                      tlb_done_i,
    input  logic                      tlb_found_i,
    input  logic [TLB_IDX_W-1:0]      tlb_index_i,
    output logic                      stall_o,
    output logic                      srch_we_o,
    output logic                      srch_found_o,
    output logic [TLB_IDX_W-1:0]      srch_index_o,
    output logic                      refetch_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_t;

    state_t               state_q;
    tlb_op_t              buf_op_q  [2];
    logic    [4:0]        buf_inv_q [2];
    logic    [1:0]        cnt_q;
    logic                 abort_q;
    logic                 srch_we_q;
    logic                 srch_found_q;
    logic [TLB_IDX_W-1:0] srch_index_q;

    tlb_op_t    cap_op  [2];
    logic [4:0] cap_inv [2];
    logic [1:0] cap_cnt;
    logic       capture;
    logic       done_now;
    logic       abort_now;

    // Pack valid slots densely, lowest slot first, into the two buffer entries.
    always_comb begin
        cap_op  = '{default: TlbSrch};
        cap_inv = '{default: 5'd0};
        cap_cnt = 2'd0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (op_valid_i[i] && cap_cnt < 2'd2) begin
                cap_op[cap_cnt[0]]  = tlb_op_t'(op_type_i[3*i +: 3]);
                cap_inv[cap_cnt[0]] = inv_op_i[5*i +: 5];
                cap_cnt             = cap_cnt + 2'd1;
            end
        end
    end

    assign capture   = (state_q == StIdle) && (|op_valid_i) && !flush_i;
    assign done_now  = ((state_q == StReq) && tlb_ack_i && tlb_done_i) ||
                       ((state_q == StWait) && tlb_done_i);
    assign abort_now = abort_q || flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            buf_op_q     <= '{default: TlbSrch};
            buf_inv_q    <= '{default: 5'd0};
            cnt_q        <= 2'd0;
            abort_q      <= 1'b0;
            srch_we_q    <= 1'b0;
            srch_found_q <= 1'b0;
            srch_index_q <= '0;
        end else begin
            srch_we_q <= 1'b0;
            if (done_now) begin
                if (buf_op_q[0] == TlbSrch) begin
                    srch_we_q    <= 1'b1;
                    srch_found_q <= tlb_found_i;
                    srch_index_q <= tlb_index_i;
                end
                buf_op_q[0]  <= buf_op_q[1];
                buf_inv_q[0] <= buf_inv_q[1];
                if (abort_now) begin
                    cnt_q   <= 2'd0;
                    abort_q <= 1'b0;
                    state_q <= StIdle;
                end else if (cnt_q > 2'd1) begin
                    cnt_q   <= cnt_q - 2'd1;
                    state_q <= StReq;
                end else begin
                    cnt_q   <= 2'd0;
                    state_q <= StDone;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (capture) begin
                            buf_op_q  <= cap_op;
                            buf_inv_q <= cap_inv;
                            cnt_q     <= cap_cnt;
                            abort_q   <= 1'b0;
                            state_q   <= StReq;
                        end
                    end
                    StReq: begin
                        if (flush_i && !tlb_ack_i) begin
                            cnt_q   <= 2'd0;
                            state_q <= StIdle;
                        end else if (tlb_ack_i) begin
                            // A flush racing the ack cannot recall the op; let it finish.
                            abort_q <= abort_q | flush_i;
                            state_q <= StWait;
                        end
                    end
                    StWait: begin
                        if (flush_i) begin
                            abort_q <= 1'b1;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign tlb_req_o    = (state_q == StReq);
    assign tlb_op_o     = tlb_req_o ? buf_op_q[0] : 3'd0;
    assign tlb_inv_op_o = tlb_req_o ? buf_inv_q[0] : 5'd0;
    assign stall_o      = !rst && ((state_q == StReq) || (state_q == StWait) || capture);
    assign refetch_o    = (state_q == StDone);
    assign srch_we_o    = srch_we_q;
    assign srch_found_o = srch_found_q;
    assign srch_index_o = srch_index_q;

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed scoreboard bench for tlb_op_sequencer: expected TLB handshakes, SRCH writebacks and
// refetch pulses are queued by the stimulus and matched by an independent monitor.
module tb_tlb_op_sequencer;
    import tlb_types::*;

    localparam int CW = 2;
    localparam int IW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CW-1:0]   op_valid;
    logic [3*CW-1:0] op_type;
    logic [5*CW-1:0] inv_op;
    logic            flush, ack, done, found;
    logic [IW-1:0]   index;
    logic            tlb_req, stall, srch_we, srch_found, refetch;
    logic [2:0]      tlb_op;
    logic [4:0]      tlb_inv_op;
    logic [IW-1:0]   srch_index;

    typedef enum int {EvReq, EvSrch, EvRefetch} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        logic [2:0]    op;
        logic [4:0]    inv;
        logic          found;
        logic [IW-1:0] idx;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    tlb_op_sequencer #(.COMMIT_WIDTH(CW), .TLB_IDX_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid_i  (op_valid),
        .op_type_i   (op_type),
        .inv_op_i    (inv_op),
        .flush_i     (flush),
        .tlb_req_o   (tlb_req),
        .tlb_op_o    (tlb_op),
        .tlb_inv_op_o(tlb_inv_op),
        .tlb_ack_i   (ack),
        .tlb_done_i  (done),
        .tlb_found_i (found),
        .tlb_index_i (index),
        .stall_o     (stall),
        .srch_we_o   (srch_we),
        .srch_found_o(srch_found),
        .srch_index_o(srch_index),
        .refetch_o   (refetch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_req(input tlb_op_t op, input logic [4:0] inv);
        ev_t e;
        e = '{kind: EvReq, op: op, inv: inv, found: 1'b0, idx: '0};
        exp_q.push_back(e);
    endtask

    task automatic push_srch(input logic f, input logic [IW-1:0] i);
        ev_t e;
        e = '{kind: EvSrch, op: 3'd0, inv: 5'd0, found: f, idx: i};
        exp_q.push_back(e);
    endtask

    task automatic push_ref();
        ev_t e;
        e = '{kind: EvRefetch, op: 3'd0, inv: 5'd0, found: 1'b0, idx: '0};
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k, input logic [2:0] op, input logic [4:0] inv,
                           input logic f, input logic [IW-1:0] i);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: actual kind %0d required none", k);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", k, e.kind);
        if (k == e.kind && k == EvReq) begin
            chk("req_op", op, e.op);
            if (e.op == TlbInv) chk("req_inv_op", inv, e.inv);
        end else if (k == e.kind && k == EvSrch) begin
            chk("srch_found", f, e.found);
            chk("srch_index", i, e.idx);
        end
    endtask

    // Monitor: one event per accepted request, SRCH writeback and refetch pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (tlb_req && ack) observe(EvReq, tlb_op, tlb_inv_op, 1'b0, '0);
            if (srch_we)        observe(EvSrch, 3'd0, 5'd0, srch_found, srch_index);
            if (refetch)        observe(EvRefetch, 3'd0, 5'd0, 1'b0, '0);
        end
    end

    task automatic clear_in();
        op_valid = '0; op_type = '0; inv_op = '0; flush = 1'b0;
        ack = 1'b0; done = 1'b0; found = 1'b0; index = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        clear_in();
        op_valid = 2'b01;
        mid();
        chk("rst_req", tlb_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_refetch", refetch, 0);
        chk("rst_srch_we", srch_we, 0);
        step(); rst = 1'b0; clear_in();
        step();

        // Single SRCH: ack one cycle after req, done one cycle later, hit at index 7.
        op_valid = 2'b01; op_type = {3'(TlbWr), 3'(TlbSrch)}; push_req(TlbSrch, 5'd0);
        mid(); chk("srch_capture_stall", stall, 1); chk("srch_capture_req", tlb_req, 0);
        step(); clear_in();
        mid(); chk("srch_req", tlb_req, 1); chk("srch_req_op", tlb_op, TlbSrch);
        chk("srch_req_stall", stall, 1);
        step(); ack = 1'b1;
        mid(); chk("srch_req_held", tlb_req, 1);
        step(); ack = 1'b0;
        mid(); chk("srch_wait_req", tlb_req, 0); chk("srch_wait_stall", stall, 1);
        step(); done = 1'b1; found = 1'b1; index = 5'd7; push_srch(1'b1, 5'd7); push_ref();
        mid(); chk("srch_done_stall", stall, 1);
        step(); clear_in();
        mid(); chk("srch_done_state_stall", stall, 0); chk("srch_we_pulse", srch_we, 1);
        chk("srch_refetch", refetch, 1);
        step();
        mid(); chk("srch_we_one", srch_we, 0); chk("refetch_one", refetch, 0);
        chk("srch_index_held", srch_index, 7);
        chk("srch_q_empty", exp_q.size(), 0);

        // WR in slot 0 and INV(5) in slot 1 in the same cycle.
        step(); op_valid = 2'b11; op_type = {3'(TlbInv), 3'(TlbWr)}; inv_op = {5'd5, 5'd0};
        push_req(TlbWr, 5'd0); push_req(TlbInv, 5'd5); push_ref();
        step(); clear_in(); ack = 1'b1; done = 1'b1;
        mid(); chk("pair_first_op", tlb_op, TlbWr);
        step(); ack = 1'b1; done = 1'b0;
        mid(); chk("pair_second_req", tlb_req, 1); chk("pair_second_op", tlb_op, TlbInv);
        chk("pair_second_inv", tlb_inv_op, 5);
        step(); ack = 1'b0; done = 1'b1;
        mid(); chk("pair_wait_req", tlb_req, 0); chk("pair_wait_stall", stall, 1);
        step(); clear_in();
        mid(); chk("pair_refetch", refetch, 1); chk("pair_done_stall", stall, 0);
        step(); step();
        mid(); chk("pair_q_empty", exp_q.size(), 0);

        // FILL flushed while still waiting for ack.
        step(); op_valid = 2'b01; op_type = {3'(TlbRd), 3'(TlbFill)};
        step(); clear_in(); flush = 1'b1;
        mid(); chk("fill_req", tlb_req, 1); chk("fill_op", tlb_op, TlbFill);
        step(); clear_in();
        mid(); chk("fill_flushed_req", tlb_req, 0); chk("fill_flushed_stall", stall, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            mid(); chk("fill_idle_req", tlb_req, 0); chk("fill_idle_refetch", refetch, 0);
        end

        // RD then WR queued; flush during the RD wait discards the WR.
        step(); op_valid = 2'b11; op_type = {3'(TlbWr), 3'(TlbRd)}; push_req(TlbRd, 5'd0);
        step(); clear_in(); ack = 1'b1;
        step(); clear_in(); flush = 1'b1;
        mid(); chk("abort_wait_req", tlb_req, 0); chk("abort_wait_stall", stall, 1);
        step(); clear_in(); done = 1'b1;
        mid(); chk("abort_done_stall", stall, 1);
        for (int c = 0; c < 4; c++) begin
            step(); clear_in();
            mid(); chk("abort_no_req", tlb_req, 0); chk("abort_no_stall", stall, 0);
        end
        chk("abort_q_empty", exp_q.size(), 0);

        // RD acked and done in the same cycle: no WAIT cycle.
        step(); op_valid = 2'b01; op_type = {3'(TlbWr), 3'(TlbRd)};
        push_req(TlbRd, 5'd0); push_ref();
        step(); clear_in(); ack = 1'b1; done = 1'b1;
        mid(); chk("fast_req", tlb_req, 1);
        step(); clear_in();
        mid(); chk("fast_refetch", refetch, 1); chk("fast_stall", stall, 0);
        chk("fast_req_low", tlb_req, 0);
        step();
        mid(); chk("fast_refetch_one", refetch, 0);

        // Reset while waiting on a SRCH.
        step(); op_valid = 2'b01; op_type = {3'(TlbWr), 3'(TlbSrch)}; push_req(TlbSrch, 5'd0);
        step(); clear_in(); ack = 1'b1;
        step(); clear_in();
        mid(); chk("rstw_wait_stall", stall, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstw_req", tlb_req, 0); chk("rstw_stall", stall, 0);
        chk("rstw_refetch", refetch, 0);
        step(); rst = 1'b0; done = 1'b1; found = 1'b1; index = 5'd3;
        mid(); chk("rstw_idle_req", tlb_req, 0); chk("rstw_idle_stall", stall, 0);
        step(); clear_in();
        mid(); chk("rstw_no_srch_we", srch_we, 0); chk("rstw_no_refetch", refetch, 0);
        chk("rstw_srch_index", srch_index, 0);

        // Only slot 1 valid: SRCH miss becomes the head.
        step(); op_valid = 2'b10; op_type = {3'(TlbSrch), 3'(TlbWr)};
        push_req(TlbSrch, 5'd0); push_srch(1'b0, 5'd26); push_ref();
        step(); clear_in(); ack = 1'b1; done = 1'b1; found = 1'b0; index = 5'd26;
        mid(); chk("slot1_req", tlb_req, 1); chk("slot1_op", tlb_op, TlbSrch);
        step(); clear_in();
        mid(); chk("slot1_srch_we", srch_we, 1); chk("slot1_found", srch_found, 0);
        step(); step();
        mid(); chk("final_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
